// File: rtl/calc_sequencer.sv
// Command sequencer for the UART calculator: gathers A, B and OP words, runs the ALU once,
// and returns result_lo (and optionally result_hi) through the word transmitter.
module calc_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned OP_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          SEND_HI        = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    word_in,
  input  logic                word_valid,
  output logic [WIDTH-1:0]    operand_a,
  output logic [WIDTH-1:0]    operand_b,
  output logic [OP_WIDTH-1:0] op_select,
  input  logic [WIDTH-1:0]    result_lo,
  input  logic [WIDTH-1:0]    result_hi,
  output logic [WIDTH-1:0]    tx_word,
  output logic                tx_start,
  input  logic                tx_ready,
  input  logic                tx_done,
  output logic                busy,
  output logic                op_err,
  output logic                overrun,
  output logic                timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StGetOp,
    StExec,
    StSendLo,
    StWaitLo,
    StSendHi,
    StWaitHi
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;

  logic op_ok;
  logic tmo_hit;
  logic accepting;

  assign op_ok     = (word_in[WIDTH-1:OP_WIDTH] == '0);
  assign tmo_hit   = TimeoutEn && (cnt_q == CntLast);
  assign accepting = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
  assign busy      = (state_q != StGetA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StGetA;
      cnt_q     <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      operand_a <= '0;
      operand_b <= '0;
      op_select <= '0;
      tx_word   <= '0;
      tx_start  <= 1'b0;
      op_err    <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      op_err   <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= word_valid && !accepting;

      unique case (state_q)
        StGetA: begin
          if (word_valid) begin
            operand_a <= word_in;
            cnt_q     <= '0;
            state_q   <= StGetB;
          end
        end
        StGetB: begin
          // An accepted word beats a timeout expiring in the same cycle.
          if (word_valid) begin
            operand_b <= word_in;
            cnt_q     <= '0;
            state_q   <= StGetOp;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            cnt_q   <= '0;
            state_q <= StGetA;
          end else if (TimeoutEn) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StGetOp: begin
          if (word_valid) begin
            cnt_q <= '0;
            if (op_ok) begin
              op_select <= word_in[OP_WIDTH-1:0];
              state_q   <= StExec;
            end else begin
              op_err  <= 1'b1;
              state_q <= StGetA;
            end
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            cnt_q   <= '0;
            state_q <= StGetA;
          end else if (TimeoutEn) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StExec: begin
          res_lo_q <= result_lo;
          res_hi_q <= result_hi;
          state_q  <= StSendLo;
        end
        StSendLo: begin
          if (tx_ready) begin
            tx_word  <= res_lo_q;
            tx_start <= 1'b1;
            state_q  <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (tx_done) state_q <= SEND_HI ? StSendHi : StGetA;
        end
        StSendHi: begin
          if (tx_ready) begin
            tx_word  <= res_hi_q;
            tx_start <= 1'b1;
            state_q  <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (tx_done) state_q <= StGetA;
        end
        default: state_q <= StGetA;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: table vectors, hand-written corner sequences and random commands
// checked against a command-level model of the words the transmitter should receive.
module tb_calc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] word_in;
  logic        word_valid;
  logic        tx_ready;
  logic        tx_done;

  logic [31:0] operand_a, operand_b, tx_word, alu_lo, alu_hi;
  logic [3:0]  op_select;
  logic        tx_start, busy, op_err, overrun, timeout;

  logic [31:0] operand_a2, operand_b2, tx_word2, alu_lo2, alu_hi2;
  logic [3:0]  op_select2;
  logic        tx_start2, busy2, op_err2, overrun2, timeout2;

  function automatic logic [63:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op);
    case (op)
      4'd0:    return {32'b0, a} + {32'b0, b};
      4'd1:    return {32'b0, a} * {32'b0, b};
      4'd2:    return {32'b0, a} - {32'b0, b};
      default: return {a & b, a ^ b};
    endcase
  endfunction

  assign {alu_hi, alu_lo}   = alu(operand_a, operand_b, op_select);
  assign {alu_hi2, alu_lo2} = alu(operand_a2, operand_b2, op_select2);

  calc_sequencer #(.WIDTH(32), .OP_WIDTH(4), .TIMEOUT_CYCLES(20), .SEND_HI(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .operand_a(operand_a), .operand_b(operand_b), .op_select(op_select),
    .result_lo(alu_lo), .result_hi(alu_hi), .tx_word(tx_word), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .op_err(op_err),
    .overrun(overrun), .timeout(timeout)
  );

  calc_sequencer #(.WIDTH(32), .OP_WIDTH(4), .TIMEOUT_CYCLES(20), .SEND_HI(1'b0)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .operand_a(operand_a2), .operand_b(operand_b2), .op_select(op_select2),
    .result_lo(alu_lo2), .result_hi(alu_hi2), .tx_word(tx_word2), .tx_start(tx_start2),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy2), .op_err(op_err2),
    .overrun(overrun2), .timeout(timeout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy for tx_lat cycles after tx_start, then a one-cycle tx_done.
  logic tx_busy;
  logic hold_ready;
  int   tx_lat;
  int   tx_cnt;
  assign tx_ready = !tx_busy && !hold_ready;

  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tx_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (!rst_n) begin
        tx_cnt  = 0;
        tx_busy = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end
      end else if (tx_start) begin
        tx_busy = 1'b1;
        tx_cnt  = tx_lat;
      end
    end
  end

  logic [31:0] got_main[$];
  logic [31:0] got_lo[$];
  int n_err, n_ovr, n_tmo;

  initial begin
    n_err = 0;
    n_ovr = 0;
    n_tmo = 0;
  end

  always @(negedge clk) begin
    if (tx_start)  got_main.push_back(tx_word);
    if (tx_start2) got_lo.push_back(tx_word2);
    if (op_err)    n_err = n_err + 1;
    if (overrun)   n_ovr = n_ovr + 1;
    if (timeout)   n_tmo = n_tmo + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] opw,
                         input int gap);
    send_word(a);
    repeat (gap) tick();
    send_word(b);
    repeat (gap) tick();
    send_word(opw);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || busy2 || tx_busy) && k < 2000) begin
      tick();
      k++;
    end
    chk("idle_reached", {62'b0, busy, busy2}, 64'd0);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!tx_start && k < 100) begin
      tick();
      k++;
    end
    chk("start_seen", {63'b0, tx_start}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] opw;
    bit          err;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int m0, l0, e0, o0, t0, bad;
    logic [3:0] last_op;
    logic [31:0] exp_main[$];
    logic [31:0] exp_lo[$];
    int exp_err, exp_ovr;

    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_000C, 32'h0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001,
                32'hFFFF_FFFE};
    vecs[2] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0100, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b0, 32'h0000_0001,
                32'h0000_0001};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0002, 1'b0, 32'hFFFF_FFFE,
                32'hFFFF_FFFF};
    vecs[5] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0007, 1'b0, 32'h0FF0_0FF0,
                32'hF000_F000};

    rst_n      = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    hold_ready = 1'b0;
    tx_lat     = 4;
    last_op    = 4'd0;
    repeat (3) tick();
    chk("rst_ops", {operand_a, operand_b}, 64'd0);
    chk("rst_outs", {tx_word, 4'b0, op_select, 20'b0, tx_start, busy, op_err, overrun,
                     timeout}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      m0 = got_main.size();
      l0 = got_lo.size();
      e0 = n_err;
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].opw, i % 3);
      if (vecs[i].err) begin
        chk("err_pulse", {63'b0, op_err}, 64'd1);
        chk("err_idle", {63'b0, busy}, 64'd0);
        chk("err_keep_op", {60'b0, op_select}, {60'b0, last_op});
        tick();
        chk("err_one_cycle", {63'b0, op_err}, 64'd0);
      end else begin
        last_op = vecs[i].opw[3:0];
        chk("operand_a", {32'b0, operand_a}, {32'b0, vecs[i].a});
        chk("operand_b", {32'b0, operand_b}, {32'b0, vecs[i].b});
        tick();
        chk("lat_exec", {63'b0, tx_start}, 64'd0);
        tick();
        chk("lat_start", {63'b0, tx_start}, 64'd1);
      end
      wait_idle();
      chk("err_count", 64'(n_err - e0), {63'b0, vecs[i].err});
      if (vecs[i].err) begin
        chk("no_tx_main", 64'(got_main.size() - m0), 64'd0);
        chk("no_tx_lo", 64'(got_lo.size() - l0), 64'd0);
      end else begin
        chk("tx_count", 64'(got_main.size() - m0), 64'd2);
        if (got_main.size() - m0 == 2) begin
          chk("tx_lo", {32'b0, got_main[m0]}, {32'b0, vecs[i].lo});
          chk("tx_hi", {32'b0, got_main[m0 + 1]}, {32'b0, vecs[i].hi});
        end
        chk("lo_only_count", 64'(got_lo.size() - l0), 64'd1);
        if (got_lo.size() - l0 == 1) chk("lo_only_word", {32'b0, got_lo[l0]}, {32'b0, vecs[i].lo});
      end
    end

    // Back-pressure, then an overrun during WAIT_LO
    m0 = got_main.size();
    o0 = n_ovr;
    hold_ready = 1'b1;
    run_cmd(32'h11, 32'h22, 32'h0, 0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_start || operand_a != 32'h11 || operand_b != 32'h22 || op_select != 4'd0) bad++;
      tick();
    end
    chk("bp_hold", 64'(bad), 64'd0);
    hold_ready = 1'b0;
    wait_start();
    send_word(32'hDEAD_BEEF);
    chk("ovr_pulse", {63'b0, overrun}, 64'd1);
    chk("ovr_busy", {63'b0, busy}, 64'd1);
    wait_idle();
    chk("ovr_count", 64'(n_ovr - o0), 64'd1);
    chk("bp_count", 64'(got_main.size() - m0), 64'd2);
    if (got_main.size() - m0 == 2) begin
      chk("bp_lo", {32'b0, got_main[m0]}, 64'h33);
      chk("bp_hi", {32'b0, got_main[m0 + 1]}, 64'h0);
    end
    chk("bp_opa_kept", {32'b0, operand_a}, 64'h11);

    // Timeout: A only, then 20 idle cycles
    t0 = n_tmo;
    send_word(32'h1234);
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      if (timeout || !busy) bad++;
      tick();
    end
    chk("tmo_early", 64'(bad), 64'd0);
    tick();
    chk("tmo_pulse", {62'b0, timeout, busy}, 64'b10);
    tick();
    chk("tmo_one_cycle", {63'b0, timeout}, 64'd0);
    chk("tmo_count", 64'(n_tmo - t0), 64'd1);

    // Word on the expiry cycle is accepted as B
    m0 = got_main.size();
    t0 = n_tmo;
    send_word(32'h100);
    repeat (19) tick();
    send_word(32'h23);
    chk("exp_no_tmo", {62'b0, timeout, busy}, 64'b01);
    chk("exp_b", {32'b0, operand_b}, 64'h23);
    send_word(32'h0);
    wait_idle();
    chk("exp_tmo_count", 64'(n_tmo - t0), 64'd0);
    chk("exp_tx_count", 64'(got_main.size() - m0), 64'd2);
    if (got_main.size() - m0 == 2) chk("exp_lo", {32'b0, got_main[m0]}, 64'h123);

    // Reset mid-send
    run_cmd(32'h40, 32'h2, 32'h0, 0);
    wait_start();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ops", {operand_a, operand_b}, 64'd0);
    chk("mid_rst_outs", {tx_word, 4'b0, op_select, 20'b0, tx_start, busy, op_err, overrun,
                         timeout}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m0 = got_main.size();
    run_cmd(32'h9, 32'h4, 32'h2, 1);
    wait_idle();
    chk("post_rst_count", 64'(got_main.size() - m0), 64'd2);
    if (got_main.size() - m0 == 2) begin
      chk("post_rst_lo", {32'b0, got_main[m0]}, 64'h5);
      chk("post_rst_hi", {32'b0, got_main[m0 + 1]}, 64'h0);
    end

    // Random commands against the command-level model
    m0 = got_main.size();
    l0 = got_lo.size();
    e0 = n_err;
    o0 = n_ovr;
    exp_err = 0;
    exp_ovr = 0;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b, opw;
      logic [63:0] r;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) opw = (32'($urandom_range(1, 4095)) << 4) | 32'($urandom_range(0, 15));
      else opw = 32'($urandom_range(0, 15));
      tx_lat = $urandom_range(3, 8);
      run_cmd(a, b, opw, $urandom_range(0, 4));
      if (opw[31:4] != 0) begin
        exp_err++;
      end else begin
        r = alu(a, b, opw[3:0]);
        exp_main.push_back(r[31:0]);
        exp_main.push_back(r[63:32]);
        exp_lo.push_back(r[31:0]);
        if ($urandom_range(0, 3) == 0) begin
          send_word($urandom);
          exp_ovr++;
        end
      end
      wait_idle();
    end
    chk("rnd_err", 64'(n_err - e0), 64'(exp_err));
    chk("rnd_ovr", 64'(n_ovr - o0), 64'(exp_ovr));
    chk("rnd_main_count", 64'(got_main.size() - m0), 64'(exp_main.size()));
    chk("rnd_lo_count", 64'(got_lo.size() - l0), 64'(exp_lo.size()));
    for (int i = 0; i < exp_main.size() && m0 + i < got_main.size(); i++)
      chk("rnd_main_word", {32'b0, got_main[m0 + i]}, {32'b0, exp_main[i]});
    for (int i = 0; i < exp_lo.size() && l0 + i < got_lo.size(); i++)
      chk("rnd_lo_word", {32'b0, got_lo[l0 + i]}, {32'b0, exp_lo[i]});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
